// File: rtl/i2s_rx_master.sv
// I2S master receiver: divides clk_i into bclk/lrclk and deserialises one
// AUDIO_WORD_LEN word per channel slot, presented at the following slot edge.
module i2s_rx_master #(
  parameter int CLK_DIVISION    = 14,
  parameter int AUDIO_FRAME_LEN = 64,
  parameter int AUDIO_WORD_LEN  = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      audio_data_i,
  output logic                      bclk_o,
  output logic                      lrclk_o,
  output logic [AUDIO_WORD_LEN-1:0] audio_data_o,
  output logic                      channel_o,
  output logic                      new_sample_o
);
  localparam int SLOT_LEN = AUDIO_FRAME_LEN / 2;
  localparam int DIV_W    = $clog2(CLK_DIVISION);
  localparam int SLOT_W   = $clog2(SLOT_LEN);

  localparam logic [DIV_W-1:0]  RISE_AT   = DIV_W'(CLK_DIVISION / 2 - 1);
  localparam logic [DIV_W-1:0]  FALL_AT   = DIV_W'(CLK_DIVISION - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] WORD_LAST = SLOT_W'(AUDIO_WORD_LEN);

  logic [DIV_W-1:0]          div_cnt;
  logic [SLOT_W-1:0]         slot_bit_cnt;
  logic [AUDIO_WORD_LEN-1:0] shreg;
  logic                      rise_stb, fall_stb, slot_end, capture;

  // Bit 0 of each slot is the I2S one-bit delay; bits past the word are padding.
  always_comb begin
    rise_stb = enable_i && (div_cnt == RISE_AT);
    fall_stb = enable_i && (div_cnt == FALL_AT);
    slot_end = fall_stb && (slot_bit_cnt == SLOT_LAST);
    capture  = rise_stb && (slot_bit_cnt != '0) && (slot_bit_cnt <= WORD_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt      <= '0;
      slot_bit_cnt <= '0;
      shreg        <= '0;
      bclk_o       <= 1'b0;
      lrclk_o      <= 1'b0;
      audio_data_o <= '0;
      channel_o    <= 1'b0;
      new_sample_o <= 1'b0;
    end else begin
      new_sample_o <= 1'b0;
      if (!enable_i) begin
        // Output word and channel deliberately hold while idle.
        div_cnt      <= '0;
        slot_bit_cnt <= '0;
        shreg        <= '0;
        bclk_o       <= 1'b0;
        lrclk_o      <= 1'b0;
      end else begin
        div_cnt <= fall_stb ? '0 : div_cnt + 1'b1;
        if (rise_stb) bclk_o <= 1'b1;
        if (capture)  shreg  <= {shreg[AUDIO_WORD_LEN-2:0], audio_data_i};
        if (fall_stb) begin
          bclk_o <= 1'b0;
          if (slot_end) begin
            slot_bit_cnt <= '0;
            lrclk_o      <= ~lrclk_o;
            audio_data_o <= shreg;
            channel_o    <= lrclk_o;
            new_sample_o <= 1'b1;
            shreg        <= '0;
          end else begin
            slot_bit_cnt <= slot_bit_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: a codec model drives random words by absolute clk
// count since enable; expected clocks and words come from plain arithmetic on that count.
module tb_i2s_rx_master;
  localparam int DIV   = 14;
  localparam int FRAME = 64;
  localparam int WL    = 24;
  localparam int SLOT  = DIV * FRAME / 2;  // clks per slot

  logic          clk_i = 1'b0;
  logic          rst_i, enable_i, audio_data_i;
  logic          bclk_o, lrclk_o, channel_o, new_sample_o;
  logic [WL-1:0] audio_data_o;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n        = 0;  // enabled clk edges since last reset/enable
  logic [WL-1:0] words [256];   // word carried by slot s (counted from n=0)
  logic          pad_high = 1'b0;
  logic [WL-1:0] exp_data = '0;
  logic          exp_ch   = 1'b0;

  i2s_rx_master #(.CLK_DIVISION(DIV), .AUDIO_FRAME_LEN(FRAME), .AUDIO_WORD_LEN(WL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .audio_data_i(audio_data_i),
    .bclk_o(bclk_o), .lrclk_o(lrclk_o), .audio_data_o(audio_data_o),
    .channel_o(channel_o), .new_sample_o(new_sample_o)
  );

  always #5 clk_i = ~clk_i;

  // Bit present on the wire at edge k: bit index within the slot is the number
  // of completed bclk periods; index 1..WL carries the word MSB first.
  function automatic logic wire_bit(int k);
    int bp = ((k - 1) / DIV) % (FRAME / 2);
    int s  = (k - 1) / SLOT;
    if (bp >= 1 && bp <= WL) return words[s % 256][WL - bp];
    return pad_high ? 1'b1 : 1'(((k - 1) / DIV) % 2);
  endfunction

  function automatic logic exp_bclk(int c);
    return (c % DIV) >= DIV / 2;
  endfunction

  function automatic logic exp_lr(int c);
    return 1'((c / SLOT) % 2);
  endfunction

  function automatic logic exp_stb(int c);
    return (c > 0) && (c % SLOT == 0);
  endfunction

  task automatic step();
    audio_data_i = wire_bit(n + 1);
    @(posedge clk_i);
    if (rst_i || !enable_i) n = 0; else n++;
    #1;
  endtask

  task automatic randomize_words();
    for (int s = 0; s < 256; s++) words[s] = WL'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1; audio_data_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if ({bclk_o, lrclk_o, channel_o, new_sample_o} !== 4'b0)
      $display("FAIL reset_ctl got %b required 0000", {bclk_o, lrclk_o, channel_o, new_sample_o});
    else n_pass++;
    n_checks++;
    if (audio_data_o !== '0) $display("FAIL reset_data got %h required 0", audio_data_o);
    else n_pass++;
    rst_i = 1'b0; enable_i = 1'b0;
    step();
  endtask

  task automatic test_clock();
    int   first_rise = -1;
    int   last_tog   = -1;
    logic prev_lr    = 1'b0;
    randomize_words();
    pad_high = 1'b0;
    enable_i = 1'b1;
    for (int i = 1; i <= 2 * SLOT + 40; i++) begin
      step();
      n_checks++;
      if (bclk_o !== exp_bclk(n)) $display("FAIL bclk n=%0d got %b required %b", n, bclk_o, exp_bclk(n));
      else n_pass++;
      n_checks++;
      if (lrclk_o !== exp_lr(n)) $display("FAIL lrclk n=%0d got %b required %b", n, lrclk_o, exp_lr(n));
      else n_pass++;
      if (first_rise < 0 && bclk_o === 1'b1) first_rise = i;
      if (lrclk_o !== prev_lr) begin
        n_checks++;
        if (bclk_o !== 1'b0) $display("FAIL lr_on_fall i=%0d bclk got %b required 0", i, bclk_o);
        else n_pass++;
        if (last_tog >= 0) begin
          n_checks++;
          if (i - last_tog != SLOT) $display("FAIL lr_period got %0d required %0d", i - last_tog, SLOT);
          else n_pass++;
        end
        last_tog = i;
        prev_lr  = lrclk_o;
      end
      if (exp_stb(n)) begin
        exp_data = words[(n / SLOT - 1) % 256];
        exp_ch   = 1'((n / SLOT - 1) % 2);
      end
      n_checks++;
      if (new_sample_o !== exp_stb(n) || audio_data_o !== exp_data || channel_o !== exp_ch)
        $display("FAIL sample n=%0d stb %b/%b data %h/%h ch %b/%b", n, new_sample_o, exp_stb(n),
                 audio_data_o, exp_data, channel_o, exp_ch);
      else n_pass++;
    end
    n_checks++;
    if (first_rise != DIV / 2) $display("FAIL first_rise got %0d required %0d", first_rise, DIV / 2);
    else n_pass++;
  endtask

  task automatic test_stream(input logic [WL-1:0] w, input logic pad);
    int s = n / SLOT + 1;
    words[s % 256] = w;
    pad_high = pad;
    while (n < SLOT * (s + 1)) begin
      step();
      if (exp_stb(n)) begin
        exp_data = words[(n / SLOT - 1) % 256];
        exp_ch   = 1'((n / SLOT - 1) % 2);
      end
      n_checks++;
      if (new_sample_o !== exp_stb(n) || audio_data_o !== exp_data || channel_o !== exp_ch)
        $display("FAIL stream n=%0d stb %b/%b data %h/%h ch %b/%b", n, new_sample_o, exp_stb(n),
                 audio_data_o, exp_data, channel_o, exp_ch);
      else n_pass++;
    end
    n_checks++;
    if (new_sample_o !== 1'b1 || audio_data_o !== w || channel_o !== 1'(s % 2))
      $display("FAIL stream_word stb %b data %h required %h ch %b required %b",
               new_sample_o, audio_data_o, w, channel_o, 1'(s % 2));
    else n_pass++;
    pad_high = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s = n / SLOT + 1;
    int stb_at[$];
    logic [WL-1:0] got[$];
    logic          got_ch[$];
    words[s % 256]       = 24'h20F3FB;
    words[(s + 1) % 256] = 24'h20F3F7;
    while (n < SLOT * (s + 2)) begin
      step();
      if (n > SLOT * s && new_sample_o === 1'b1) begin
        stb_at.push_back(n);
        got.push_back(audio_data_o);
        got_ch.push_back(channel_o);
      end
    end
    n_checks++;
    if (stb_at.size() != 2) $display("FAIL b2b_count got %0d required 2", stb_at.size());
    else begin
      n_pass++;
      n_checks++;
      if (stb_at[1] - stb_at[0] != SLOT) $display("FAIL b2b_gap got %0d required %0d", stb_at[1] - stb_at[0], SLOT);
      else n_pass++;
      n_checks++;
      if (got[0] !== 24'h20F3FB || got[1] !== 24'h20F3F7)
        $display("FAIL b2b_data got %h,%h required 20f3fb,20f3f7", got[0], got[1]);
      else n_pass++;
      n_checks++;
      if (got_ch[0] !== 1'(s % 2) || got_ch[1] !== 1'((s + 1) % 2))
        $display("FAIL b2b_ch got %b,%b required %b,%b", got_ch[0], got_ch[1], 1'(s % 2), 1'((s + 1) % 2));
      else n_pass++;
    end
    exp_data = 24'h20F3F7;
    exp_ch   = 1'((s + 1) % 2);
  endtask

  task automatic test_mid_reset();
    int stop = n + SLOT / 2 + int'($urandom_range(0, 50));
    while (n < stop) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_checks++;
    if ({bclk_o, lrclk_o, channel_o, new_sample_o} !== 4'b0 || audio_data_o !== '0)
      $display("FAIL midreset got ctl %b data %h required 0", {bclk_o, lrclk_o, channel_o, new_sample_o}, audio_data_o);
    else n_pass++;
    exp_data = '0;
    exp_ch   = 1'b0;
    randomize_words();
    for (int i = 0; i < SLOT + 20; i++) begin
      step();
      if (exp_stb(n)) begin
        exp_data = words[(n / SLOT - 1) % 256];
        exp_ch   = 1'((n / SLOT - 1) % 2);
      end
      n_checks++;
      if (bclk_o !== exp_bclk(n) || lrclk_o !== exp_lr(n) || new_sample_o !== exp_stb(n) ||
          audio_data_o !== exp_data || channel_o !== exp_ch)
        $display("FAIL after_reset n=%0d bclk %b/%b lr %b/%b stb %b/%b data %h/%h", n, bclk_o, exp_bclk(n),
                 lrclk_o, exp_lr(n), new_sample_o, exp_stb(n), audio_data_o, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    int stop = n + SLOT + int'($urandom_range(20, 200));
    while (n < stop) begin
      step();
      if (exp_stb(n)) begin
        exp_data = words[(n / SLOT - 1) % 256];
        exp_ch   = 1'((n / SLOT - 1) % 2);
      end
    end
    enable_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      n_checks++;
      if (bclk_o !== 1'b0 || lrclk_o !== 1'b0 || new_sample_o !== 1'b0 ||
          audio_data_o !== exp_data || channel_o !== exp_ch)
        $display("FAIL disabled i=%0d bclk %b lr %b stb %b data %h/%h ch %b/%b", i, bclk_o, lrclk_o,
                 new_sample_o, audio_data_o, exp_data, channel_o, exp_ch);
      else n_pass++;
    end
    enable_i = 1'b1;
    randomize_words();
    for (int i = 0; i < SLOT + 20; i++) begin
      step();
      if (exp_stb(n)) begin
        exp_data = words[(n / SLOT - 1) % 256];
        exp_ch   = 1'((n / SLOT - 1) % 2);
      end
      n_checks++;
      if (bclk_o !== exp_bclk(n) || lrclk_o !== exp_lr(n) || new_sample_o !== exp_stb(n) ||
          audio_data_o !== exp_data || channel_o !== exp_ch)
        $display("FAIL reenable n=%0d bclk %b/%b lr %b/%b stb %b/%b data %h/%h", n, bclk_o, exp_bclk(n),
                 lrclk_o, exp_lr(n), new_sample_o, exp_stb(n), audio_data_o, exp_data);
      else n_pass++;
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; audio_data_i = 1'b0;
    for (int s = 0; s < 256; s++) words[s] = '0;
    test_reset();
    test_clock();
    test_stream(24'h20F3FF, 1'b0);
    test_back_to_back();
    test_stream(24'h000000, 1'b1);
    test_stream(WL'($urandom), 1'b0);
    test_mid_reset();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2s_rx_master.md
Name: i2s_rx_master

Overview:
- I2S master-mode receiver: generates bit clock and word-select (LR) clock from the system clock and deserialises the incoming serial audio stream.
- Every channel slot produces one word.
- Sits between an external I2S ADC/codec (slave) and the on-chip audio datapath.
- Combines the clock-generation function and the receive function in one block.

Parameters:
- CLK_DIVISION, 14, system clocks per bclk period; even, >= 4.
- AUDIO_FRAME_LEN, 64, bclk periods per full LR frame (two slots); even.
- AUDIO_WORD_LEN, 24, bits captured per slot; AUDIO_WORD_LEN+1 <= AUDIO_FRAME_LEN/2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  run enable; low holds clocks idle and counters cleared.
- audio_data_i  in  1  serial data from codec; changes after bclk falling edge.
- bclk_o  out  1  I2S bit clock.
- lrclk_o  out  1  word-select; 0 = left slot, 1 = right slot.
- audio_data_o  out  AUDIO_WORD_LEN  last complete received word, MSB first on the wire.
- channel_o  out  1  slot (lrclk level) that audio_data_o came from.
- new_sample_o  out  1  one-clk strobe: audio_data_o/channel_o just updated.

Behaviour:
- Reset (rst_i=1 at a clk edge): all outputs = 0; div_cnt, slot_bit_cnt and shift register = 0. Reset is honoured at any point, mid-frame included; the next frame starts from cnt 0 with lrclk_o = 0.
- enable_i=0 has the same effect on counters, bclk_o and lrclk_o as reset. audio_data_o and channel_o hold their values; new_sample_o = 0.
- Clock divider (enable_i=1): div_cnt counts 0..CLK_DIVISION-1 and wraps.
  - On the clk where div_cnt == CLK_DIVISION/2-1: bclk_o <= 1 (rise strobe).
  - On the clk where div_cnt == CLK_DIVISION-1: bclk_o <= 0 (fall strobe).
  - Result: 50% duty; first rise CLK_DIVISION/2 clks after enable.
- Slot counter: slot_bit_cnt advances on each fall strobe, range 0..AUDIO_FRAME_LEN/2-1.
  - When it wraps to 0, lrclk_o toggles in the same clk as bclk_o falls.
  - lrclk_o period = AUDIO_FRAME_LEN*CLK_DIVISION clks.
- Capture: on the rise strobe clk, sample audio_data_i.
  - slot_bit_cnt 0 is the I2S one-bit delay and is ignored.
  - slot_bit_cnt 1..AUDIO_WORD_LEN shift in MSB first.
  - Bits beyond AUDIO_WORD_LEN are ignored (padding).
- Output update: on the clk where lrclk_o toggles:
  - audio_data_o <= shift register; channel_o <= old lrclk_o level; new_sample_o = 1 for exactly that clk.
  - Shift register then clears for the next slot.
- The first slot after reset/enable also produces a strobe; its data is whatever was sampled.
- Latency: last data bit sampled mid-slot; the word appears at the slot boundary.
- audio_data_o is stable between strobes.

Test Plan:
- Clock check (defaults, enable=1 after reset) -> bclk_o period 14 clks (7 high/7 low); lrclk_o toggles every 448 clks, coincident with bclk_o fall; first bclk_o rise 7 clks after enable.
- Stream 0x20F3FF MSB first, bits driven on bclk falls starting one bclk after an lrclk edge -> strobe at the next lrclk edge with audio_data_o = 0x20F3FF and channel_o = slot level.
- Back-to-back slots 0x20F3FB then 0x20F3F7 (left/right alternating) -> two consecutive strobes 448 clks apart with those values; no strobe in between.
- Padding bits 25..31 driven to 1 after word 0x000000 -> audio_data_o = 0x000000.
- Assert rst_i mid-slot -> next clk all outputs 0, counters restart; no strobe for the aborted slot.
- Drop enable_i mid-frame for 100 clks -> bclk_o/lrclk_o held 0, audio_data_o holds; on re-enable timing restarts from div_cnt 0.
